usb2_ts_ep3_writer: RTL and testbench



---
 rtl/usb2_ts_pkg.sv | 23 ++
 rtl/usb2_ts_ep3_writer.sv | 230 +++++++++++++++++++++++
 tb/tb_usb2_ts_ep3_writer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb2_ts_pkg.sv
// Shared definitions for the EP3 transport-stream writer: FSM states, TS constants,
// port widths and the saturating drop-counter increment.
package usb2_ts_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_READY,
        ST_COLLECT,
        ST_COMMIT,
        ST_ACK_WAIT
    } ts_state_e;

    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam logic [12:0] TS_NULL_PID  = 13'h1FFF;

    localparam int unsigned TS_ADDR_W = 11;
    localparam int unsigned TS_LEN_W  = 11;
    localparam int unsigned TS_DROP_W = 16;

    function automatic logic [TS_DROP_W-1:0] sat_inc(input logic [TS_DROP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/usb2_ts_ep3_writer.sv
// Packs a parallel MPEG-TS byte stream into PKT_LEN-byte packets and writes them into the
// EP3 isochronous IN buffer, committing PKTS_PER_XFER packets (or a partial buffer after
// FLUSH_TIMEOUT idle cycles). Define TS_NULL_FILTER_EN to discard null (PID 0x1FFF) packets.
module usb2_ts_ep3_writer
    import usb2_ts_pkg::*;
#(
    parameter int unsigned PKT_LEN       = 188,
    parameter int unsigned PKTS_PER_XFER = 5,
    parameter int unsigned FLUSH_TIMEOUT = 4096
) (
    input  logic                 ep3_ext_clk,
    input  logic                 reset_n,
    input  logic [7:0]           ts_data,
    input  logic                 ts_valid,
    input  logic                 ts_start,
    input  logic                 ts_err,
    output logic [TS_ADDR_W-1:0] buf_in_addr,
    output logic [7:0]           buf_in_data,
    output logic                 buf_in_wren,
    input  logic                 buf_in_ready,
    output logic                 buf_in_commit,
    output logic [TS_LEN_W-1:0]  buf_in_commit_len,
    input  logic                 buf_in_commit_ack,
    output logic [TS_DROP_W-1:0] drop_cnt,
    output logic                 sync_err
);

    localparam int unsigned IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [10:0] PKT_LEN_W = 11'(PKT_LEN);
    localparam logic [10:0] LAST_IDX  = 11'(PKT_LEN - 1);
    localparam logic [10:0] XFER_PKTS = 11'(PKTS_PER_XFER);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

    if (PKT_LEN * PKTS_PER_XFER > 2047) begin : g_len_check
        $error("PKT_LEN*PKTS_PER_XFER must not exceed 2047");
    end
    if (FLUSH_TIMEOUT < 1) begin : g_flush_check
        $error("FLUSH_TIMEOUT must be at least 1");
    end

    ts_state_e             state_q, state_d;
    logic [10:0]           pkt_base_q, pkt_base_d;
    logic [10:0]           byte_idx_q, byte_idx_d;
    logic [10:0]           pkt_cnt_q, pkt_cnt_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  open_q, open_d;
    logic                  bad_q, bad_d;
    logic [TS_ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  wren_q, wren_d;
    logic                  commit_q, commit_d;
    logic [TS_LEN_W-1:0]   len_q, len_d;
    logic [TS_DROP_W-1:0]  drop_q, drop_d;
    logic                  sync_q, sync_d;

    logic                  accept, restart, bad_sync, last_byte, bad_now, null_now;
    logic [10:0]           cur_idx;

    // Decode whether this cycle's byte is written and at which packet offset.
    always_comb begin
        accept   = 1'b0;
        restart  = 1'b0;
        bad_sync = 1'b0;
        cur_idx  = byte_idx_q;
        if (state_q == ST_COLLECT && ts_valid) begin
            if (ts_start) begin
                if (ts_data != TS_SYNC_BYTE) begin
                    bad_sync = 1'b1;
                end else begin
                    accept  = 1'b1;
                    restart = 1'b1;
                    cur_idx = '0;
                end
            end else if (open_q) begin
                accept = 1'b1;
            end
        end
    end

    assign last_byte = accept && (cur_idx == LAST_IDX);
    // A fresh start forgets errors of any discarded partial packet.
    assign bad_now   = ts_err | (bad_q & ~restart);

`ifdef TS_NULL_FILTER_EN
    logic [4:0] pid_hi_q, pid_hi_d;
    logic       null_q, null_d;

    // Capture the PID from header bytes 1 and 2 and flag null packets.
    always_comb begin
        pid_hi_d = pid_hi_q;
        null_now = null_q & ~restart;
        if (accept && cur_idx == 11'd1) pid_hi_d = ts_data[4:0];
        if (accept && cur_idx == 11'd2) null_now = ({pid_hi_q, ts_data} == TS_NULL_PID);
        null_d = last_byte ? 1'b0 : null_now;
    end

    // PID tracking state.
    always_ff @(posedge ep3_ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            pid_hi_q <= '0;
            null_q   <= 1'b0;
        end else begin
            pid_hi_q <= pid_hi_d;
            null_q   <= null_d;
        end
    end
`else
    assign null_now = 1'b0;
`endif

    // Next-state and registered-output logic of the writer FSM.
    always_comb begin
        state_d    = state_q;
        pkt_base_d = pkt_base_q;
        byte_idx_d = byte_idx_q;
        pkt_cnt_d  = pkt_cnt_q;
        idle_d     = idle_q;
        open_d     = open_q;
        bad_d      = bad_q;
        drop_d     = drop_q;
        commit_d   = 1'b0;
        len_d      = '0;
        wren_d     = accept;
        addr_d     = accept ? (pkt_base_q + cur_idx) : addr_q;
        data_d     = accept ? ts_data : data_q;
        sync_d     = bad_sync | (restart & open_q);

        unique case (state_q)
            ST_WAIT_READY: begin
                if (ts_valid && ts_start) drop_d = sat_inc(drop_q);
                if (buf_in_ready) begin
                    state_d    = ST_COLLECT;
                    pkt_base_d = '0;
                    pkt_cnt_d  = '0;
                    byte_idx_d = '0;
                    open_d     = 1'b0;
                    bad_d      = 1'b0;
                    idle_d     = '0;
                end
            end
            ST_COLLECT: begin
                if (ts_valid) begin
                    idle_d = '0;
                end else if (pkt_cnt_q != '0 && !open_q) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d = ST_COMMIT;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + IDLE_ONE;
                    end
                end
                if (last_byte) begin
                    open_d     = 1'b0;
                    byte_idx_d = '0;
                    bad_d      = 1'b0;
                    if (bad_now) begin
                        drop_d = sat_inc(drop_q);
                    end else if (!null_now) begin
                        pkt_cnt_d  = pkt_cnt_q + 11'd1;
                        pkt_base_d = pkt_base_q + PKT_LEN_W;
                        if (pkt_cnt_d == XFER_PKTS) state_d = ST_COMMIT;
                    end
                end else if (accept) begin
                    open_d     = 1'b1;
                    byte_idx_d = cur_idx + 11'd1;
                    bad_d      = bad_now;
                end
            end
            ST_COMMIT: begin
                if (ts_valid && ts_start) drop_d = sat_inc(drop_q);
                // Ack only counts once the request is visible on the port.
                if (commit_q && buf_in_commit_ack) begin
                    state_d = ST_ACK_WAIT;
                end else begin
                    commit_d = 1'b1;
                    len_d    = pkt_cnt_q * PKT_LEN_W;
                end
            end
            ST_ACK_WAIT: begin
                if (ts_valid && ts_start) drop_d = sat_inc(drop_q);
                if (!buf_in_commit_ack) state_d = ST_WAIT_READY;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge ep3_ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_WAIT_READY;
            pkt_base_q <= '0;
            byte_idx_q <= '0;
            pkt_cnt_q  <= '0;
            idle_q     <= '0;
            open_q     <= 1'b0;
            bad_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
            commit_q   <= 1'b0;
            len_q      <= '0;
            drop_q     <= '0;
            sync_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pkt_base_q <= pkt_base_d;
            byte_idx_q <= byte_idx_d;
            pkt_cnt_q  <= pkt_cnt_d;
            idle_q     <= idle_d;
            open_q     <= open_d;
            bad_q      <= bad_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
            commit_q   <= commit_d;
            len_q      <= len_d;
            drop_q     <= drop_d;
            sync_q     <= sync_d;
        end
    end

    assign buf_in_addr       = addr_q;
    assign buf_in_data       = data_q;
    assign buf_in_wren       = wren_q;
    assign buf_in_commit     = commit_q;
    assign buf_in_commit_len = len_q;
    assign drop_cnt          = drop_q;
    assign sync_err          = sync_q;

endmodule

// File: tb/tb_usb2_ts_ep3_writer.sv
// Bench for usb2_ts_ep3_writer: directed scenarios plus randomized traffic, checked every
// cycle against a packet-level reference model.
module tb_usb2_ts_ep3_writer;

    localparam int PKT_LEN = 188;
    localparam int PKTS    = 5;
    localparam int FLUSH   = 4096;
`ifdef TS_NULL_FILTER_EN
    localparam bit NULL_EN = 1'b1;
`else
    localparam bit NULL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  ts_data = '0;
    logic        ts_valid = 1'b0, ts_start = 1'b0, ts_err = 1'b0;
    logic        buf_in_ready = 1'b0, buf_in_commit_ack = 1'b0;
    logic [10:0] buf_in_addr, buf_in_commit_len;
    logic [7:0]  buf_in_data;
    logic        buf_in_wren, buf_in_commit, sync_err;
    logic [15:0] drop_cnt;

    usb2_ts_ep3_writer dut (
        .ep3_ext_clk       (clk),
        .reset_n           (reset_n),
        .ts_data           (ts_data),
        .ts_valid          (ts_valid),
        .ts_start          (ts_start),
        .ts_err            (ts_err),
        .buf_in_addr       (buf_in_addr),
        .buf_in_data       (buf_in_data),
        .buf_in_wren       (buf_in_wren),
        .buf_in_ready      (buf_in_ready),
        .buf_in_commit     (buf_in_commit),
        .buf_in_commit_len (buf_in_commit_len),
        .buf_in_commit_ack (buf_in_commit_ack),
        .drop_cnt          (drop_cnt),
        .sync_err          (sync_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    int sync_count = 0;
    logic [10:0] last_addr = '0;
    bit ack_auto = 1'b0;
    bit rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int P_WAIT = 0, P_FILL = 1, P_HANDOFF = 2, P_RELEASE = 3;
    int          m_phase;
    int          m_base, m_good, m_idle, m_drop;
    logic [7:0]  m_pkt[$];
    bit          m_errs[$];

    logic        exp_wren, exp_sync, exp_commit;
    logic [10:0] exp_addr, exp_len;
    logic [7:0]  exp_data;
    logic [15:0] exp_drop;

    task automatic model_reset();
        m_phase = P_WAIT;
        m_base = 0; m_good = 0; m_idle = 0; m_drop = 0;
        m_pkt.delete(); m_errs.delete();
        exp_wren = 0; exp_sync = 0; exp_commit = 0;
        exp_addr = '0; exp_len = '0; exp_data = '0; exp_drop = '0;
    endtask

    task automatic drop_one();
        if (m_drop < 65535) m_drop++;
    endtask

    // Consumes this cycle's inputs; produces the outputs expected after the next edge.
    task automatic model_step();
        bit strt, pkt_bad, is_null, n_commit;
        logic [12:0] pid;
        strt = ts_valid && ts_start;
        exp_wren = 0;
        exp_sync = 0;
        n_commit = 0;
        exp_len  = '0;
        case (m_phase)
            P_WAIT: begin
                if (strt) drop_one();
                if (buf_in_ready) begin
                    m_phase = P_FILL; m_base = 0; m_good = 0; m_idle = 0;
                    m_pkt.delete(); m_errs.delete();
                end
            end
            P_FILL: begin
                if (ts_valid) begin
                    m_idle = 0;
                    if (ts_start && ts_data != 8'h47) begin
                        exp_sync = 1;
                    end else if (ts_start || m_pkt.size() > 0) begin
                        if (ts_start) begin
                            if (m_pkt.size() > 0) exp_sync = 1;
                            m_pkt.delete(); m_errs.delete();
                        end
                        exp_wren = 1;
                        exp_addr = 11'(m_base + m_pkt.size());
                        exp_data = ts_data;
                        m_pkt.push_back(ts_data);
                        m_errs.push_back(ts_err);
                        if (m_pkt.size() == PKT_LEN) begin
                            pkt_bad = 0;
                            foreach (m_errs[i]) pkt_bad |= m_errs[i];
                            pid = {m_pkt[1][4:0], m_pkt[2]};
                            is_null = NULL_EN && (pid == 13'h1FFF);
                            if (pkt_bad) drop_one();
                            else if (!is_null) begin
                                m_good++;
                                m_base += PKT_LEN;
                                if (m_good == PKTS) m_phase = P_HANDOFF;
                            end
                            m_pkt.delete(); m_errs.delete();
                        end
                    end
                end else if (m_good > 0 && m_pkt.size() == 0) begin
                    m_idle++;
                    if (m_idle == FLUSH) begin
                        m_phase = P_HANDOFF;
                        m_idle = 0;
                    end
                end
            end
            P_HANDOFF: begin
                if (strt) drop_one();
                n_commit = !(exp_commit && buf_in_commit_ack);
                if (n_commit) exp_len = 11'(m_good * PKT_LEN);
                else m_phase = P_RELEASE;
            end
            default: begin
                if (strt) drop_one();
                if (!buf_in_commit_ack) m_phase = P_WAIT;
            end
        endcase
        exp_commit = n_commit;
        exp_drop = 16'(m_drop);
    endtask

    // Per-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) model_reset();
        chk("wren", 32'(buf_in_wren), 32'(exp_wren));
        if (exp_wren) begin
            chk("addr", 32'(buf_in_addr), 32'(exp_addr));
            chk("data", 32'(buf_in_data), 32'(exp_data));
        end
        chk("sync_err", 32'(sync_err), 32'(exp_sync));
        chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        chk("commit", 32'(buf_in_commit), 32'(exp_commit));
        chk("commit_len", 32'(buf_in_commit_len), 32'(exp_len));
        if (buf_in_wren) begin
            wr_count++;
            last_addr = buf_in_addr;
        end
        if (sync_err) sync_count++;
        if (reset_n) model_step();
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic s, input logic [7:0] d, input logic e);
        @(posedge clk);
        #1;
        ts_valid = v; ts_start = s; ts_data = d; ts_err = e;
        if (rand_ready) buf_in_ready = ($urandom_range(3) != 0);
        if (ack_auto) begin
            if (buf_in_commit_ack) buf_in_commit_ack = 1'($urandom_range(1));
            else buf_in_commit_ack = buf_in_commit && ($urandom_range(2) == 0);
        end
    endtask

    task automatic idle_step();
        step(1'b0, 1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)));
    endtask

    task automatic send_pkt(input int nbytes, input int err_at, input logic [12:0] pid,
                            input int gap_pct);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) idle_step();
            if (i == 0) b = 8'h47;
            else if (i == 1) b = {3'($urandom), pid[12:8]};
            else if (i == 2) b = pid[7:0];
            else b = 8'($urandom);
            step(1'b1, i == 0, b, i == err_at);
        end
    endtask

    function automatic logic [12:0] good_pid();
        return 13'($urandom_range(8190));
    endfunction

    task automatic wait_commit(input int max_cycles);
        int n = 0;
        while (!buf_in_commit && n < max_cycles) begin
            idle_step();
            n++;
        end
        if (!buf_in_commit) chk("commit_timeout", 32'(buf_in_commit), 32'd1);
    endtask

    task automatic do_ack();
        buf_in_commit_ack = 1'b1;
        idle_step();
        buf_in_commit_ack = 1'b0;
        repeat (3) idle_step();
    endtask

    int drop0, sync0;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not end, got running, want finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_drop", 32'(drop_cnt), 32'd0);
        chk("reset_commit", 32'(buf_in_commit), 32'd0);
        chk("reset_wren", 32'(buf_in_wren), 32'd0);
        reset_n = 1'b1;
        buf_in_ready = 1'b1;
        repeat (3) idle_step();

        // Five clean packets back to back.
        wr_count = 0;
        repeat (5) send_pkt(PKT_LEN, -1, good_pid(), 0);
        wait_commit(50);
        chk("A_len", 32'(buf_in_commit_len), 32'd940);
        chk("A_model_len", 32'(exp_len), 32'd940);
        chk("A_writes", 32'(wr_count), 32'd940);
        chk("A_last_addr", 32'(last_addr), 32'd939);
        do_ack();

        // Two packets then idle until flush.
        send_pkt(PKT_LEN, -1, good_pid(), 0);
        send_pkt(PKT_LEN, -1, good_pid(), 0);
        wait_commit(4200);
        chk("B_len", 32'(buf_in_commit_len), 32'd376);
        do_ack();

        // Packet interrupted by a new start after 100 bytes.
        wr_count = 0;
        sync0 = sync_count;
        send_pkt(100, -1, good_pid(), 0);
        repeat (5) send_pkt(PKT_LEN, -1, good_pid(), 0);
        wait_commit(50);
        chk("C_sync_pulses", 32'(sync_count - sync0), 32'd1);
        chk("C_writes", 32'(wr_count), 32'd1040);
        chk("C_len", 32'(buf_in_commit_len), 32'd940);
        chk("C_last_addr", 32'(last_addr), 32'd939);
        do_ack();

        // Errored third packet; its slot is reused.
        drop0 = int'(drop_cnt);
        for (int p = 0; p < 6; p++) send_pkt(PKT_LEN, (p == 2) ? 50 : -1, good_pid(), 0);
        wait_commit(50);
        chk("D_drop", 32'(int'(drop_cnt) - drop0), 32'd1);
        chk("D_len", 32'(buf_in_commit_len), 32'd940);
        chk("D_last_addr", 32'(last_addr), 32'd939);

        // Packets arriving while commit waits for ack are dropped.
        drop0 = int'(drop_cnt);
        wr_count = 0;
        repeat (3) send_pkt(PKT_LEN, -1, good_pid(), 0);
        idle_step();
        chk("E_drop", 32'(int'(drop_cnt) - drop0), 32'd3);
        chk("E_model_drop", 32'(int'(exp_drop) - drop0), 32'd3);
        chk("E_writes", 32'(wr_count), 32'd0);
        chk("E_commit_held", 32'(buf_in_commit), 32'd1);
        do_ack();

`ifdef TS_NULL_FILTER_EN
        drop0 = int'(drop_cnt);
        for (int p = 0; p < 6; p++) send_pkt(PKT_LEN, -1, (p == 2) ? 13'h1FFF : good_pid(), 0);
        wait_commit(50);
        chk("F_drop", 32'(int'(drop_cnt) - drop0), 32'd0);
        chk("F_len", 32'(buf_in_commit_len), 32'd940);
        chk("F_last_addr", 32'(last_addr), 32'd939);
        do_ack();
`endif

        // Randomized traffic with a self-driven ack and a wandering ready.
        ack_auto = 1'b1;
        rand_ready = 1'b1;
        for (int it = 0; it < 70; it++) begin
            logic [12:0] pid;
            logic [7:0] bogus;
            pid = ($urandom_range(5) == 0) ? 13'h1FFF : 13'($urandom);
            case ($urandom_range(9))
                0, 1, 2, 3, 4: send_pkt(PKT_LEN, -1, pid, 10);
                5: send_pkt(PKT_LEN, $urandom_range(PKT_LEN - 1), pid, 5);
                6: send_pkt($urandom_range(1, PKT_LEN - 1), -1, pid, 0);
                7: begin
                    bogus = 8'($urandom);
                    if (bogus == 8'h47) bogus = 8'h48;
                    step(1'b1, 1'b1, bogus, 1'($urandom_range(1)));
                end
                8: repeat ($urandom_range(1, 40)) idle_step();
                default: send_pkt(PKT_LEN, -1, pid, 0);
            endcase
            if (it == 20 || it == 50) repeat (FLUSH + 10) idle_step();
        end
        repeat (50) idle_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
